// File: rtl/vga_overlay_renderer.sv
// ============================================================================
// Module   : vga_overlay_renderer
// Purpose  : VGA back end with its own sync generator. Composites a 4-bit
//            grayscale frame with up to NUM_BOX detection boxes and drives
//            12-bit RGB plus active-low syncs through a 2-stage pipeline.
// Options  : `define BOX_OUTLINE_EN draws each box as a BORDER-pixel outline
//            instead of a filled rectangle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_overlay_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int WIN_X0   = 20,
    parameter int WIN_X1   = 620,
    parameter int WIN_Y0   = 40,
    parameter int WIN_Y1   = 440,
    parameter int NUM_BOX  = 4,
    parameter int BOX_HALF = 20,
    parameter int BORDER   = 2,
    parameter logic [12*NUM_BOX-1:0] BOX_RGB = {NUM_BOX{12'h0F0}}
) (
    input  logic                    pixel_clk,
    input  logic                    rst_n,
    input  logic [3:0]              pix_in,
    output logic [9:0]              out_x,
    output logic [8:0]              out_y,
    input  logic [10*NUM_BOX-1:0]   box_x,
    input  logic [9*NUM_BOX-1:0]    box_y,
    input  logic [NUM_BOX-1:0]      box_upd,
    input  logic [NUM_BOX-1:0]      box_clr,
    input  logic [1:0]              mode,
    output logic [3:0]              vga_r,
    output logic [3:0]              vga_g,
    output logic [3:0]              vga_b,
    output logic                    vga_hs,
    output logic                    vga_vs,
    output logic                    frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] C_H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] C_V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] C_H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] C_V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] C_HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] C_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] C_VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] C_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] C_WX0    = 10'(WIN_X0);
    localparam logic [9:0] C_WX1    = 10'(WIN_X1);
    localparam logic [9:0] C_WY0    = 10'(WIN_Y0);
    localparam logic [9:0] C_WY1    = 10'(WIN_Y1);
    // One bit of headroom over 11 bits so x+BOX_HALF never overflows for any centre
    localparam logic signed [11:0] C_HALF = 12'(BOX_HALF);
`ifdef BOX_OUTLINE_EN
    localparam logic signed [11:0] C_BORDER = 12'(BORDER);
`endif

    logic [9:0]                 hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic                       frame_tick_q, frame_tick_d, copy_now;
    logic [NUM_BOX-1:0]         prev_upd_q;
    logic [NUM_BOX-1:0]         sh_v_q, sh_v_d, act_v_q, act_v_d;
    logic [NUM_BOX-1:0][9:0]    sh_x_q, sh_x_d, act_x_q, act_x_d;
    logic [NUM_BOX-1:0][8:0]    sh_y_q, sh_y_d, act_y_q, act_y_d;
    logic [NUM_BOX-1:0]         box_hit;
    logic                       hs1_q, hs1_d, vs1_q, vs1_d, win1_q, win1_d, hit1_q, hit1_d;
    logic [11:0]                col1_q, col1_d;
    logic                       hs2_q, vs2_q;
    logic [11:0]                rgb_q, rgb_d;
    logic signed [11:0]         h_s, v_s;

    assign out_x      = hcnt_q;
    assign out_y      = vcnt_q[8:0];
    assign vga_r      = rgb_q[11:8];
    assign vga_g      = rgb_q[7:4];
    assign vga_b      = rgb_q[3:0];
    assign vga_hs     = hs2_q;
    assign vga_vs     = vs2_q;
    assign frame_tick = frame_tick_q;

    // Raster counters; frame_tick is decoded from the next state so it lines up with (0, V_ACTIVE)
    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == C_H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == C_V_LAST) ? '0 : vcnt_q + 10'd1;
        end
        copy_now     = (hcnt_q == '0) && (vcnt_q == C_V_ACT);
        frame_tick_d = (hcnt_d == '0) && (vcnt_d == C_V_ACT);
    end

    // Shadow capture on upd rising edge (clear dominates); shadow->active copy at frame boundary
    always_comb begin
        sh_v_d  = sh_v_q;
        sh_x_d  = sh_x_q;
        sh_y_d  = sh_y_q;
        act_v_d = act_v_q;
        act_x_d = act_x_q;
        act_y_d = act_y_q;
        for (int i = 0; i < NUM_BOX; i++) begin
            if (box_clr[i]) begin
                sh_v_d[i] = 1'b0;
            end else if (box_upd[i] && !prev_upd_q[i]) begin
                sh_v_d[i] = 1'b1;
                sh_x_d[i] = box_x[10*i +: 10];
                sh_y_d[i] = box_y[9*i +: 9];
            end
        end
        // Copy uses the pre-update shadow, so a same-cycle upd lands one frame later
        if (copy_now) begin
            act_v_d = sh_v_q;
            act_x_d = sh_x_q;
            act_y_d = sh_y_q;
        end
    end

    assign h_s = $signed({2'b00, hcnt_q});
    assign v_s = $signed({2'b00, vcnt_q});

    generate
        for (genvar i = 0; i < NUM_BOX; i++) begin : g_box
            logic signed [11:0] cx, cy, lo_x_raw, lo_y_raw, lo_x, lo_y, hi_x, hi_y;
            logic               in_rect;
            assign cx       = $signed({2'b00, act_x_q[i]});
            assign cy       = $signed({3'b000, act_y_q[i]});
            assign lo_x_raw = cx - C_HALF;
            assign lo_y_raw = cy - C_HALF;
            // Clamp at zero instead of wrapping to the far edge of the raster
            assign lo_x     = lo_x_raw[11] ? 12'sd0 : lo_x_raw;
            assign lo_y     = lo_y_raw[11] ? 12'sd0 : lo_y_raw;
            assign hi_x     = cx + C_HALF;
            assign hi_y     = cy + C_HALF;
            assign in_rect  = act_v_q[i] && (h_s >= lo_x) && (h_s < hi_x)
                                         && (v_s >= lo_y) && (v_s < hi_y);
`ifdef BOX_OUTLINE_EN
            logic on_edge;
            assign on_edge    = (h_s < lo_x + C_BORDER) || (h_s >= hi_x - C_BORDER) ||
                                (v_s < lo_y + C_BORDER) || (v_s >= hi_y - C_BORDER);
            assign box_hit[i] = in_rect && on_edge;
`else
            assign box_hit[i] = in_rect;
`endif
        end
    endgenerate

    // Stage 1: syncs, window flag and prioritised box hit for the current counter position
    always_comb begin
        hs1_d  = !((hcnt_q >= C_HS_BEG) && (hcnt_q < C_HS_END));
        vs1_d  = !((vcnt_q >= C_VS_BEG) && (vcnt_q < C_VS_END));
        win1_d = (hcnt_q < C_H_ACT) && (vcnt_q < C_V_ACT) &&
                 (hcnt_q >= C_WX0) && (hcnt_q < C_WX1) &&
                 (vcnt_q >= C_WY0) && (vcnt_q < C_WY1);
        hit1_d = 1'b0;
        col1_d = '0;
        // Walk from the top index down so the lowest index wins
        for (int i = NUM_BOX - 1; i >= 0; i--) begin
            if (box_hit[i]) begin
                hit1_d = 1'b1;
                col1_d = BOX_RGB[12*i +: 12];
            end
        end
    end

    // Stage 2: composite the returned pixel with the box hit according to mode
    always_comb begin
        rgb_d = '0;
        if (win1_q) begin
            case (mode)
                2'd0:    rgb_d = {pix_in, pix_in, pix_in};
                2'd1:    rgb_d = hit1_q ? col1_q : 12'hFFF;
                2'd2:    rgb_d = hit1_q ? col1_q : {pix_in, pix_in, pix_in};
                default: rgb_d = {pix_in, pix_in >> 1, pix_in >> 1};
            endcase
        end
    end

    // All state: counters, box registers and both pipeline stages
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            frame_tick_q <= 1'b0;
            prev_upd_q   <= '0;
            sh_v_q       <= '0;
            sh_x_q       <= '0;
            sh_y_q       <= '0;
            act_v_q      <= '0;
            act_x_q      <= '0;
            act_y_q      <= '0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            win1_q       <= 1'b0;
            hit1_q       <= 1'b0;
            col1_q       <= '0;
            hs2_q        <= 1'b1;
            vs2_q        <= 1'b1;
            rgb_q        <= '0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            frame_tick_q <= frame_tick_d;
            prev_upd_q   <= box_upd;
            sh_v_q       <= sh_v_d;
            sh_x_q       <= sh_x_d;
            sh_y_q       <= sh_y_d;
            act_v_q      <= act_v_d;
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            win1_q       <= win1_d;
            hit1_q       <= hit1_d;
            col1_q       <= col1_d;
            hs2_q        <= hs1_q;
            vs2_q        <= vs1_q;
            rgb_q        <= rgb_d;
        end
    end

endmodule

`default_nettype wire
